// File: rtl/reg_cmd_pkg.sv
// Shared opcode constants and controller state encoding for the UART
// register-command controller.
package reg_cmd_pkg;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_e;

  // States in which the frame timer watches for a stalled host.
  function automatic logic is_timed(input state_e s);
    return s inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT};
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter for an open frame; expire is high for the single cycle
// in which the count sits at TIMEOUT-1 while still enabled.
module frame_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/reg_cmd_ctrl.sv
// UART command decoder: AA,addr,data writes the register file; BB,addr reads
// it and forwards the read data to the UART transmitter.
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  input  logic             TX_BUSY,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  output logic             CTRL_BUSY,
  output logic             FRAME_ERR
);

  state_e           state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic             tx_vld_q, tx_vld_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;

  logic byte_acc, rd_hit, tmr_clear, tmr_enable, tmr_expire;

  // Bytes in RD_WAIT/TX_SEND are not "accepted"; they are simply dropped.
  assign byte_acc   = RX_D_VLD && (state_q inside {WR_ADDR, WR_DATA, RD_ADDR});
  assign rd_hit     = RdData_VLD && (state_q == RD_WAIT);
  assign tmr_clear  = !is_timed(state_q) || byte_acc || rd_hit;
  assign tmr_enable = is_timed(state_q) && !byte_acc && !rd_hit;

  frame_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_frame_timer (
    .clk   (CLK),
    .rst_n (RST),
    .clear (tmr_clear),
    .enable(tmr_enable),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    tx_data_d   = tx_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_vld_d    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (RX_D_VLD && RX_P_DATA == WIDTH'(WR_CMD)) state_d = WR_ADDR;
        else if (RX_D_VLD && RX_P_DATA == WIDTH'(RD_CMD)) state_d = RD_ADDR;
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RdData_VLD) begin
          tx_data_d = RdData;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!TX_BUSY) begin
          tx_vld_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Expiry only fires when no byte/read data arrived this cycle, so it never
    // competes with a WrEn/RdEn decision above.
    if (tmr_expire) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      tx_vld_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      tx_data_q   <= tx_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      tx_vld_q    <= tx_vld_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CTRL_BUSY = busy_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 Parameter WIDTH, 8, data and byte width for RX, TX and the register file.
REQ-002 Parameter ADDR, 4, register-file address width, taken from the low bits of the address byte.
REQ-003 Parameter TIMEOUT, 1024, idle cycles allowed inside a frame before abort.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: CLK in 1 system clock; RST in 1 async active-low reset.
REQ-005 RX_P_DATA in WIDTH received UART byte.
REQ-006 RX_D_VLD in 1 one-cycle strobe, RX_P_DATA valid.
REQ-007 RdData in WIDTH register-file read data.
REQ-008 RdData_VLD in 1 register-file read-data valid pulse.
REQ-009 TX_BUSY in 1 UART transmitter busy.
REQ-010 WrEn out 1 register-file write enable, one-cycle pulse.
REQ-011 RdEn out 1 register-file read enable, one-cycle pulse.
REQ-012 Address out ADDR register-file address.
REQ-013 WrData out WIDTH register-file write data.
REQ-014 TX_P_DATA out WIDTH byte to transmit.
REQ-015 TX_D_VLD out 1 one-cycle strobe, TX_P_DATA valid.
REQ-016 CTRL_BUSY out 1 high whenever the FSM is not IDLE.
REQ-017 FRAME_ERR out 1 one-cycle pulse on timeout abort.

Function
REQ-018 Opcodes SHALL be: 0xAA write frame (AA, addr, data); 0xBB read frame (BB, addr); any other byte in IDLE is discarded with no output activity.
REQ-019 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
REQ-020 Transitions: IDLE+AA -> WR_ADDR; IDLE+BB -> RD_ADDR; WR_ADDR+byte -> WR_DATA; WR_DATA+byte -> IDLE; RD_ADDR+byte -> RD_WAIT; RD_WAIT+RdData_VLD -> TX_SEND; TX_SEND with TX_BUSY low -> IDLE.
REQ-021 Address SHALL be loaded from RX_P_DATA[ADDR-1:0] on the address byte and held until the next address byte.
REQ-022 On the data byte in WR_DATA, WrData<=RX_P_DATA and WrEn SHALL be high for exactly the next cycle only.
REQ-023 On the address byte in RD_ADDR, RdEn SHALL be high for exactly the next cycle only; WrEn and RdEn SHALL never be high together.
REQ-024 In RD_WAIT, RdData SHALL be captured into TX_P_DATA on the cycle RdData_VLD is high.
REQ-025 In TX_SEND, TX_D_VLD SHALL pulse one cycle on the first cycle TX_BUSY is low; while TX_BUSY is high, the FSM SHALL hold and TX_D_VLD SHALL stay low.
REQ-026 RX_D_VLD strobes arriving in RD_WAIT or TX_SEND SHALL be dropped, without affecting state.
REQ-027 A frame timer SHALL clear on entry to WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT and on every accepted byte, and count otherwise in those states.
REQ-028 When the frame timer reaches TIMEOUT-1, the FSM SHALL return to IDLE, pulse FRAME_ERR, and issue no WrEn/RdEn.
REQ-029 The timer SHALL not run in IDLE or TX_SEND.
REQ-030 A RdData_VLD pulse outside RD_WAIT SHALL be ignored.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 Assertion of RST SHALL immediately force IDLE, clear the timer, and drive every output to 0, aborting any frame in progress.
REQ-033 After reset release, the first accepted byte SHALL be treated as an opcode.

Structure
REQ-034 Package reg_cmd_pkg SHALL hold the opcode constants (WR_CMD=0xAA, RD_CMD=0xBB) and the FSM state typedef.
REQ-035 The frame timer SHALL be a sub-module, frame_timer, with inputs clear and enable and a one-cycle expiry output.

Verification
REQ-036 RX AA,05,3C -> one WrEn pulse with Address=5, WrData=0x3C; CTRL_BUSY returns low.
REQ-037 RX BB,02 with the register file returning 0x81 -> one RdEn pulse with Address=2, then one TX_D_VLD pulse with TX_P_DATA=0x81.
REQ-038 Read with TX_BUSY held high for 50 cycles -> TX_D_VLD stays low, then pulses once on the first cycle TX_BUSY is low.
REQ-039 RX AA,07, then silence for TIMEOUT cycles -> FRAME_ERR pulses, no WrEn; a following BB,07 read completes normally.
REQ-040 RX 0x55 in IDLE, and RX bytes during RD_WAIT -> no outputs change and the read completes with the correct data.
REQ-041 RST asserted in WR_DATA -> all outputs are 0 at once; after release, AA,01,FF writes 0xFF to address 1.
